// File: rtl/bus_interconnect.sv
// Single-master to NUM_SLAVES address-decoding interconnect with per-access
// wait timeout. One transfer in flight; lowest-index region wins on overlap.
module bus_interconnect #(
    parameter int                            NUM_SLAVES     = 4,
    parameter int                            ADDR_W         = 32,
    parameter int                            DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  BASE_ADDR      = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  ADDR_MASK      = {NUM_SLAVES{32'hFFFF_F000}},
    parameter int                            TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bus_req,
    input  logic [ADDR_W-1:0]            bus_addr,
    input  logic                         bus_wren,
    input  logic [DATA_W-1:0]            bus_wrdata,
    output logic [DATA_W-1:0]            bus_rddata,
    output logic                         bus_ready,
    output logic                         bus_err,
    output logic [NUM_SLAVES-1:0]        slv_sel,
    output logic [ADDR_W-1:0]            slv_addr,
    output logic [NUM_SLAVES-1:0]        slv_wren,
    output logic [DATA_W-1:0]            slv_wrdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rddata,
    input  logic [NUM_SLAVES-1:0]        slv_ready
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_wren;
    logic [CNT_W-1:0]  r_cnt;

    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic [ADDR_W-1:0]     w_off;
    logic [NUM_SLAVES-1:0] w_onehot;

    // Walking from the top index down lets the lowest matching region overwrite the rest.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_hit = 1'b0;
        w_idx = '0;
        w_off = bus_addr;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus_addr & ADDR_MASK[i*ADDR_W +: ADDR_W]) == BASE_ADDR[i*ADDR_W +: ADDR_W]) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
                w_off = bus_addr & ~ADDR_MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_onehot = NUM_SLAVES'(1) << w_idx;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_wren     <= 1'b0;
            r_cnt      <= '0;
            bus_rddata <= '0;
            bus_ready  <= 1'b0;
            bus_err    <= 1'b0;
            slv_sel    <= '0;
            slv_wren   <= '0;
            slv_addr   <= '0;
            slv_wrdata <= '0;
        end else begin
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus_req) begin
                        r_wren     <= bus_wren;
                        slv_addr   <= w_off;
                        slv_wrdata <= bus_wrdata;
                        r_cnt      <= '0;
                        if (w_hit) begin
                            r_idx    <= w_idx;
                            slv_sel  <= w_onehot;
                            slv_wren <= bus_wren ? w_onehot : '0;
                            r_state  <= ACCESS;
                        end else begin
                            bus_ready <= 1'b1;
                            bus_err   <= 1'b1;
                            if (!bus_wren) bus_rddata <= '0;
                            r_state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (slv_ready[r_idx]) begin
                        slv_sel   <= '0;
                        slv_wren  <= '0;
                        bus_ready <= 1'b1;
                        if (!r_wren) bus_rddata <= slv_rddata[r_idx*DATA_W +: DATA_W];
                        r_state   <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        slv_sel   <= '0;
                        slv_wren  <= '0;
                        bus_ready <= 1'b1;
                        bus_err   <= 1'b1;
                        if (!r_wren) bus_rddata <= '0;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
